// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states, lane masks.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus word-wide RAM pins of the load/store unit.
// slave: the controller side; master: requester and RAM side.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_datain;
  logic [31:0]       mem_dataout;
  logic              mem_write;
  logic              mem_read;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dataout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_datain, mem_write,
           mem_read
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dataout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_datain, mem_write,
           mem_read
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extract/extend a sub-word load and merge a sub-word store.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  shamt;
  logic [31:0] mask;
  logic [31:0] lane;

  always_comb begin
    shamt = '0;
    mask  = '1;
    case (size_i)
      SZ_BYTE: begin
        shamt = {addr_lo_i, 3'b000};
        mask  = LANE_MASK_B << shamt;
      end
      SZ_HALF: begin
        shamt = {addr_lo_i[1], 4'b0000};
        mask  = LANE_MASK_H << shamt;
      end
      default: ;
    endcase

    lane = word_i >> shamt;
    case (size_i)
      SZ_BYTE: load_o = {{24{signed_i & lane[7]}}, lane[7:0]};
      SZ_HALF: load_o = {{16{signed_i & lane[15]}}, lane[15:0]};
      default: load_o = lane;
    endcase

    // Word size leaves mask all-ones and shamt zero, so merge reduces to wdata.
    merge_o = (word_i & ~mask) | ((wdata_i << shamt) & mask);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit between datapath and word-addressed RAM; sub-word stores use read-modify-write.
// Optional MEM_ADDR_RANGE_CHECK_EN rejects word indices >= MEM_WORDS.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  mem_access_ctrl_if.slave         bus_io
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdq_q, rdq_d;

  logic [31:0]       load_data, merge_data;
  logic              bad_req, range_err;

  logic              req_ready, resp_valid, resp_err, mem_write, mem_read;
  logic [31:0]       resp_rdata, mem_datain;
  logic [ADDR_W-1:0] mem_addr;

  mem_lane_align u_align (
    .word_i    (rdq_q),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .wdata_i   (wdata_q),
    .load_o    (load_data),
    .merge_o   (merge_data)
  );

`ifdef MEM_ADDR_RANGE_CHECK_EN
  assign range_err = bus_io.req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_WORDS);
`else
  assign range_err = 1'b0;
`endif

  assign bad_req = (bus_io.req_size == SZ_HALF && bus_io.req_addr[0])
                || (bus_io.req_size == SZ_WORD && bus_io.req_addr[1:0] != 2'b00)
                || (bus_io.req_size == 2'b11)
                || range_err;

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    signed_d   = signed_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdq_d      = rdq_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_datain = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus_io.req_valid) begin
          write_d  = bus_io.req_write;
          size_d   = bus_io.req_size;
          signed_d = bus_io.req_signed;
          addr_d   = bus_io.req_addr;
          wdata_d  = bus_io.req_wdata;
          err_d    = bad_req;
          if (bad_req) begin
            state_d = RESP;
          end else if (bus_io.req_write && bus_io.req_size == SZ_WORD) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        mem_read = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        rdq_d    = bus_io.mem_dataout;
        state_d  = write_q ? WRITE : RESP;
      end
      WRITE: begin
        // Gating by reset keeps an aborted store from committing on the reset edge.
        mem_write  = ~rst_i;
        mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
        mem_datain = merge_data;
        state_d    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || write_q) ? '0 : load_data;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdq_q    <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdq_q    <= rdq_d;
    end
  end

  assign bus_io.req_ready  = req_ready;
  assign bus_io.resp_valid = resp_valid;
  assign bus_io.resp_rdata = resp_rdata;
  assign bus_io.resp_err   = resp_err;
  assign bus_io.mem_addr   = mem_addr;
  assign bus_io.mem_datain = mem_datain;
  assign bus_io.mem_write  = mem_write;
  assign bus_io.mem_read   = mem_read;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small word RAM model; honours MEM_ADDR_RANGE_CHECK_EN.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_load = 1'b1;
  logic [31:0] ram [0:31];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] r_rdata, r_wdat;
  logic        r_err, r_pulse2, r_ready2;
  int          r_lat, r_nrd, r_nwr;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(32), .MEM_WORDS(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  assign bus.mem_dataout = ram[bus.mem_addr[6:2]];

  always @(posedge clk) begin
    if (ram_load) begin
      ram[0] <= 32'h1122_3344;
      ram[1] <= 32'h8070_60F0;
      ram[2] <= 32'hCAFE_BABE;
      ram[3] <= 32'h0000_0000;
    end else if (bus.mem_write) begin
      ram[bus.mem_addr[6:2]] <= bus.mem_datain;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    r_rdata = 'x; r_err = 1'bx; r_wdat = '0;
    r_lat = 0; r_nrd = 0; r_nwr = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.mem_read) r_nrd++;
      if (bus.mem_write) begin
        r_nwr++;
        r_wdat = bus.mem_datain;
      end
      if (bus.resp_valid) begin
        r_lat   = i;
        r_rdata = bus.resp_rdata;
        r_err   = bus.resp_err;
        break;
      end
    end
    @(negedge clk);
    r_pulse2 = bus.resp_valid;
    r_ready2 = bus.req_ready;
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] rdata, input logic err,
                             input int lat, input int nrd, input int nwr);
    check({tag, "_rdata"}, r_rdata, rdata);
    check({tag, "_err"}, 32'(r_err), 32'(err));
    check({tag, "_lat"}, 32'(r_lat), 32'(lat));
    check({tag, "_nrd"}, 32'(r_nrd), 32'(nrd));
    check({tag, "_nwr"}, 32'(r_nwr), 32'(nwr));
    check({tag, "_pulse"}, 32'(r_pulse2), 32'd0);
    check({tag, "_ready"}, 32'(r_ready2), 32'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = SZ_WORD;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ram_load = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_datain", bus.mem_datain, 32'd0);

    do_req(1'b0, SZ_WORD, 1'b0, 32'h4, '0);
    expect_resp("ld_w4", 32'h8070_60F0, 1'b0, 2, 1, 0);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h4, '0);
    expect_resp("ld_sb4", 32'hFFFF_FFF0, 1'b0, 2, 1, 0);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h6, '0);
    expect_resp("ld_uh6", 32'h0000_8070, 1'b0, 2, 1, 0);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h6, '0);
    expect_resp("ld_sh6", 32'hFFFF_8070, 1'b0, 2, 1, 0);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h7, '0);
    expect_resp("ld_ub7", 32'h0000_0080, 1'b0, 2, 1, 0);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h4, '0);
    expect_resp("ld_sh4", 32'h0000_60F0, 1'b0, 2, 1, 0);

    do_req(1'b1, SZ_BYTE, 1'b0, 32'h5, 32'h0000_00AB);
    expect_resp("st_b5", 32'h0, 1'b0, 3, 1, 1);
    check("st_b5_datain", r_wdat, 32'h8070_ABF0);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h4, '0);
    expect_resp("ld_after_sb", 32'h8070_ABF0, 1'b0, 2, 1, 0);

    do_req(1'b1, SZ_HALF, 1'b1, 32'h6, 32'hFFFF_1234);
    expect_resp("st_h6", 32'h0, 1'b0, 3, 1, 1);
    check("st_h6_datain", r_wdat, 32'h1234_ABF0);

    do_req(1'b1, SZ_WORD, 1'b0, 32'hC, 32'h0BAD_F00D);
    expect_resp("st_w12", 32'h0, 1'b0, 2, 0, 1);
    check("st_w12_datain", r_wdat, 32'h0BAD_F00D);
    do_req(1'b0, SZ_WORD, 1'b0, 32'hC, '0);
    expect_resp("ld_w12", 32'h0BAD_F00D, 1'b0, 2, 1, 0);

    do_req(1'b0, SZ_HALF, 1'b0, 32'h3, '0);
    expect_resp("mis_h3", 32'h0, 1'b1, 1, 0, 0);
    do_req(1'b1, SZ_WORD, 1'b0, 32'h2, 32'hDEAD_BEEF);
    expect_resp("mis_w2", 32'h0, 1'b1, 1, 0, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h8, '0);
    expect_resp("mis_sz3", 32'h0, 1'b1, 1, 0, 0);

    // Abort a word store with reset during its WRITE cycle.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SZ_WORD;
    bus.req_addr = 32'h8; bus.req_wdata = 32'h55AA_55AA;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_wr_gate", 32'(bus.mem_write), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
    check("abort_ram2", ram[2], 32'hCAFE_BABE);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h8, '0);
    expect_resp("ld_w8", 32'hCAFE_BABE, 1'b0, 2, 1, 0);

`ifdef MEM_ADDR_RANGE_CHECK_EN
    do_req(1'b0, SZ_WORD, 1'b0, 32'h80, '0);
    expect_resp("ld_oob", 32'h0, 1'b1, 1, 0, 0);
`else
    do_req(1'b0, SZ_WORD, 1'b0, 32'h80, '0);
    expect_resp("ld_alias", 32'h1122_3344, 1'b0, 2, 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
